// File: rtl/snake_pkg.sv
// Shared game-state and collision codes for the snake game blocks.
// Downstream blocks decode game_state with these same constants.
package snake_pkg;

    localparam logic [1:0] IDLE      = 2'b00;
    localparam logic [1:0] PLAY      = 2'b01;
    localparam logic [1:0] PAUSE     = 2'b10;
    localparam logic [1:0] GAME_OVER = 2'b11;

    localparam logic [1:0] NONE            = 2'b00;
    localparam logic [1:0] COLLISION       = 2'b01;
    localparam logic [1:0] APPLE_COLLECTED = 2'b10;

endpackage

// File: rtl/snake_game_ctrl_if.sv
// Button/collision inputs and game-flow outputs of the snake game controller.
// master drives the inputs and observes the outputs; slave is the controller.
interface snake_game_ctrl_if #(
    parameter int SCORE_W = 8,
    parameter int LEVEL_W = 3,
    parameter int LIVES_W = 2
);
    logic               up;
    logic               down;
    logic               left;
    logic               right;
    logic               pause;
    logic               frame_tick;
    logic [1:0]         collision_state;

    logic [1:0]         game_state;
    logic               move_tick;
    logic               apple_trigger;
    logic               new_game;
    logic               life_lost;
    logic [SCORE_W-1:0] score;
    logic [LEVEL_W-1:0] level;
    logic [LIVES_W-1:0] lives;

    modport master (
        output up, down, left, right, pause, frame_tick, collision_state,
        input  game_state, move_tick, apple_trigger, new_game, life_lost,
        input  score, level, lives
    );

    modport slave (
        input  up, down, left, right, pause, frame_tick, collision_state,
        output game_state, move_tick, apple_trigger, new_game, life_lost,
        output score, level, lives
    );
endinterface

// File: rtl/snake_move_timer.sv
// Snake move pacing: counts frames and pulses o_move_tick once per period,
// where the period shrinks with level down to MIN_PERIOD.
module snake_move_timer #(
    parameter int LEVEL_W      = 3,
    parameter int START_PERIOD = 8,
    parameter int MIN_PERIOD   = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_enable,
    input  logic               i_clear,
    input  logic               i_frame_tick,
    input  logic [LEVEL_W-1:0] i_level,
    output logic               o_move_tick
);
    localparam int CNT_W = $clog2(START_PERIOD + 1);

    logic [CNT_W-1:0] r_frame_cnt;
    logic [CNT_W-1:0] w_period_m1;
    logic             r_move_tick;

    // NOTE: both branches assign w_period_m1, so no latch is inferred.
    always_comb begin
        if (int'(i_level) + MIN_PERIOD >= START_PERIOD)
            w_period_m1 = CNT_W'(MIN_PERIOD - 1);
        else
            w_period_m1 = CNT_W'(START_PERIOD - 1 - int'(i_level));
    end

    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_frame_cnt <= '0;
            r_move_tick <= 1'b0;
        end else begin
            r_move_tick <= 1'b0;
            if (i_clear) begin
                r_frame_cnt <= '0;
            end else if (i_enable && i_frame_tick) begin
                // >= so a period that just shrank below the count fires at once
                if (r_frame_cnt >= w_period_m1) begin
                    r_frame_cnt <= '0;
                    r_move_tick <= 1'b1;
                end else begin
                    r_frame_cnt <= r_frame_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign o_move_tick = r_move_tick;

endmodule

// File: rtl/snake_game_ctrl.sv
// Snake game-flow controller: IDLE/PLAY/PAUSE/GAME_OVER FSM with lives,
// saturating score, level speed-up and a timed game-over hold.
module snake_game_ctrl
    import snake_pkg::*;
#(
    parameter int SCORE_W          = 8,
    parameter int LEVEL_W          = 3,
    parameter int LIVES_W          = 2,
    parameter int LIVES            = 3,
    parameter int START_PERIOD     = 8,
    parameter int MIN_PERIOD       = 2,
    parameter int APPLES_PER_LEVEL = 4,
    parameter int OVER_FRAMES      = 120
) (
    input  logic             clk,
    input  logic             reset,
    snake_game_ctrl_if.slave bus
);
    localparam int APPLE_W = $clog2(APPLES_PER_LEVEL + 1);
    localparam int HOLD_W  = $clog2(OVER_FRAMES + 1);

    logic [3:0]         r_btn_sync, r_btn_prev;
    logic               r_pause_sync, r_pause_prev;
    logic [1:0]         r_col_sync, r_col_prev;

    logic [1:0]         r_state;
    logic [SCORE_W-1:0] r_score;
    logic [LEVEL_W-1:0] r_level;
    logic [LIVES_W-1:0] r_lives;
    logic [APPLE_W-1:0] r_apple_cnt;
    logic [HOLD_W-1:0]  r_hold_cnt;
    logic               r_new_game, r_life_lost, r_apple_trigger;

    logic w_btn_ev, w_pause_ev, w_col_ev, w_apple_ev;
    logic w_start, w_playing, w_move_tick;

    // Inputs are registered once, then compared against a second copy for edges
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_btn_sync   <= '0;
            r_btn_prev   <= '0;
            r_pause_sync <= 1'b0;
            r_pause_prev <= 1'b0;
            r_col_sync   <= NONE;
            r_col_prev   <= NONE;
        end else begin
            r_btn_sync   <= {bus.right, bus.left, bus.down, bus.up};
            r_btn_prev   <= r_btn_sync;
            r_pause_sync <= bus.pause;
            r_pause_prev <= r_pause_sync;
            r_col_sync   <= bus.collision_state;
            r_col_prev   <= r_col_sync;
        end
    end

    assign w_btn_ev   = |(r_btn_sync & ~r_btn_prev);
    assign w_pause_ev = r_pause_sync & ~r_pause_prev;
    assign w_col_ev   = (r_col_sync == COLLISION) && (r_col_prev != COLLISION);
    assign w_apple_ev = (r_col_sync == APPLE_COLLECTED) && (r_col_prev != APPLE_COLLECTED);
    assign w_start    = (r_state == IDLE) && w_btn_ev;
    assign w_playing  = (r_state == PLAY);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state         <= IDLE;
            r_score         <= '0;
            r_level         <= '0;
            r_lives         <= '0;
            r_apple_cnt     <= '0;
            r_hold_cnt      <= '0;
            r_new_game      <= 1'b0;
            r_life_lost     <= 1'b0;
            r_apple_trigger <= 1'b0;
        end else begin
            r_new_game      <= 1'b0;
            r_life_lost     <= 1'b0;
            r_apple_trigger <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_btn_ev) begin
                        r_state <= PLAY;
                        // lives==0 means no game in progress: start a fresh one
                        if (r_lives == '0) begin
                            r_new_game  <= 1'b1;
                            r_score     <= '0;
                            r_level     <= '0;
                            r_apple_cnt <= '0;
                            r_lives     <= LIVES_W'(LIVES);
                        end
                    end
                end
                PLAY: begin
                    if (w_col_ev) begin
                        if (r_lives > LIVES_W'(1)) begin
                            r_lives     <= r_lives - LIVES_W'(1);
                            r_life_lost <= 1'b1;
                            r_state     <= IDLE;
                        end else begin
                            r_lives    <= '0;
                            r_hold_cnt <= '0;
                            r_state    <= GAME_OVER;
                        end
                    end else if (w_pause_ev) begin
                        r_state <= PAUSE;
                    end else if (w_apple_ev) begin
                        r_apple_trigger <= 1'b1;
                        r_score <= (&r_score) ? r_score : r_score + SCORE_W'(1);
                        if (r_apple_cnt == APPLE_W'(APPLES_PER_LEVEL - 1)) begin
                            r_apple_cnt <= '0;
                            r_level <= (&r_level) ? r_level : r_level + LEVEL_W'(1);
                        end else begin
                            r_apple_cnt <= r_apple_cnt + APPLE_W'(1);
                        end
                    end
                end
                PAUSE: begin
                    if (w_pause_ev)
                        r_state <= PLAY;
                end
                GAME_OVER: begin
                    if (bus.frame_tick) begin
                        if (r_hold_cnt == HOLD_W'(OVER_FRAMES - 1))
                            r_state <= IDLE;
                        else
                            r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    snake_move_timer #(
        .LEVEL_W      (LEVEL_W),
        .START_PERIOD (START_PERIOD),
        .MIN_PERIOD   (MIN_PERIOD)
    ) u_move_timer (
        .clk          (clk),
        .reset        (reset),
        .i_enable     (w_playing),
        .i_clear      (w_start),
        .i_frame_tick (bus.frame_tick),
        .i_level      (r_level),
        .o_move_tick  (w_move_tick)
    );

    assign bus.game_state    = r_state;
    assign bus.move_tick     = w_move_tick;
    assign bus.apple_trigger = r_apple_trigger;
    assign bus.new_game      = r_new_game;
    assign bus.life_lost     = r_life_lost;
    assign bus.score         = r_score;
    assign bus.level         = r_level;
    assign bus.lives         = r_lives;

endmodule

// File: tb/tb_snake_game_ctrl.sv
// Scoreboard bench for snake_game_ctrl: a game-rule model predicts every
// cycle's outputs; a monitor compares them against two DUTs (8-bit, 2-bit score).
`timescale 1ns/1ps
module tb_snake_game_ctrl;
    import snake_pkg::*;

    localparam int LIVES        = 3;
    localparam int START_PERIOD = 8;
    localparam int MIN_PERIOD   = 2;
    localparam int APL          = 4;
    localparam int OVER_FRAMES  = 120;

    typedef struct {
        logic [1:0] st;
        logic       mv, at, ng, ll;
        int         score, score2, level, lives;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [3:0] d_btn   = '0;
    logic       d_pause = 1'b0;
    logic       d_ft    = 1'b0;
    logic [1:0] d_col   = NONE;

    // Levels the stimulus wants; copied onto the pins right after a falling edge
    logic [3:0] c_btn   = '0;
    logic       c_pause = 1'b0;
    logic [1:0] c_col   = NONE;
    logic       c_rst   = 1'b1;

    int   n_vec = 0;
    int   n_err = 0;
    int   n_moves = 0;
    exp_t q[$];
    exp_t m_e;

    snake_game_ctrl_if #(.SCORE_W(8), .LEVEL_W(3), .LIVES_W(2)) bus ();
    snake_game_ctrl_if #(.SCORE_W(2), .LEVEL_W(3), .LIVES_W(2)) bus2 ();

    assign {bus.right, bus.left, bus.down, bus.up}     = d_btn;
    assign {bus2.right, bus2.left, bus2.down, bus2.up} = d_btn;
    assign bus.pause            = d_pause;
    assign bus2.pause           = d_pause;
    assign bus.frame_tick       = d_ft;
    assign bus2.frame_tick      = d_ft;
    assign bus.collision_state  = d_col;
    assign bus2.collision_state = d_col;

    snake_game_ctrl #(
        .SCORE_W(8), .LEVEL_W(3), .LIVES_W(2), .LIVES(LIVES),
        .START_PERIOD(START_PERIOD), .MIN_PERIOD(MIN_PERIOD),
        .APPLES_PER_LEVEL(APL), .OVER_FRAMES(OVER_FRAMES)
    ) dut (.clk(clk), .reset(reset), .bus(bus));

    snake_game_ctrl #(
        .SCORE_W(2), .LEVEL_W(3), .LIVES_W(2), .LIVES(LIVES),
        .START_PERIOD(START_PERIOD), .MIN_PERIOD(MIN_PERIOD),
        .APPLES_PER_LEVEL(APL), .OVER_FRAMES(OVER_FRAMES)
    ) dut2 (.clk(clk), .reset(reset), .bus(bus2));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (game rules) ----------------
    logic [1:0] m_st = IDLE;
    int m_score = 0, m_score2 = 0, m_level = 0, m_lives = 0;
    int m_ticks = 0, m_apples = 0, m_over = 0;
    logic [3:0] h1_btn = '0, h2_btn = '0;
    logic       h1_p = 1'b0, h2_p = 1'b0;
    logic [1:0] h1_c = NONE, h2_c = NONE;

    task automatic model_step(output exp_t e);
        bit bev, pev, cev, aev;
        int period;
        e = '{default: 0};
        if (reset) begin
            m_st = IDLE; m_score = 0; m_score2 = 0; m_level = 0; m_lives = 0;
            m_ticks = 0; m_apples = 0; m_over = 0;
            h1_btn = '0; h2_btn = '0; h1_p = 0; h2_p = 0; h1_c = NONE; h2_c = NONE;
            e.st = IDLE;
            return;
        end
        // Events see inputs captured at the previous two edges
        bev = |(h1_btn & ~h2_btn);
        pev = h1_p && !h2_p;
        cev = (h1_c == COLLISION) && (h2_c != COLLISION);
        aev = (h1_c == APPLE_COLLECTED) && (h2_c != APPLE_COLLECTED);
        h2_btn = h1_btn; h1_btn = d_btn;
        h2_p = h1_p;     h1_p = d_pause;
        h2_c = h1_c;     h1_c = d_col;

        period = START_PERIOD - m_level;
        if (period < MIN_PERIOD) period = MIN_PERIOD;
        if (m_st == PLAY && d_ft) begin
            m_ticks++;
            if (m_ticks >= period) begin
                m_ticks = 0;
                e.mv = 1'b1;
            end
        end

        case (m_st)
            IDLE: if (bev) begin
                if (m_lives == 0) begin
                    e.ng = 1'b1; m_score = 0; m_score2 = 0; m_level = 0;
                    m_apples = 0; m_lives = LIVES;
                end
                m_ticks = 0;
                m_st = PLAY;
            end
            PLAY: begin
                if (cev) begin
                    if (m_lives > 1) begin
                        m_lives--; e.ll = 1'b1; m_st = IDLE;
                    end else begin
                        m_lives = 0; m_over = 0; m_st = GAME_OVER;
                    end
                end else if (pev) begin
                    m_st = PAUSE;
                end else if (aev) begin
                    e.at = 1'b1;
                    if (m_score < 255) m_score++;
                    if (m_score2 < 3) m_score2++;
                    m_apples++;
                    if (m_apples == APL) begin
                        m_apples = 0;
                        if (m_level < 7) m_level++;
                    end
                end
            end
            PAUSE: if (pev) m_st = PLAY;
            default: if (d_ft) begin
                m_over++;
                if (m_over == OVER_FRAMES) m_st = IDLE;
            end
        endcase
        e.st = m_st; e.score = m_score; e.score2 = m_score2;
        e.level = m_level; e.lives = m_lives;
    endtask

    // ---------------- monitor ----------------
    always @(posedge clk) begin
        #1;
        if (q.size() > 0) begin
            m_e = q.pop_front();
            if (bus.move_tick === 1'b1) n_moves++;
            check("game_state",    bus.game_state,    m_e.st);
            check("move_tick",     bus.move_tick,     m_e.mv);
            check("apple_trigger", bus.apple_trigger, m_e.at);
            check("new_game",      bus.new_game,      m_e.ng);
            check("life_lost",     bus.life_lost,     m_e.ll);
            check("score",         bus.score,         m_e.score);
            check("level",         bus.level,         m_e.level);
            check("lives",         bus.lives,         m_e.lives);
            check("score_w2",      bus2.score,        m_e.score2);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input logic ft);
        exp_t e;
        @(negedge clk);
        reset   = c_rst;
        d_btn   = c_btn;
        d_pause = c_pause;
        d_col   = c_col;
        d_ft    = ft;
        model_step(e);
        q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0);
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            tick(1'b1);
            idle(2);
        end
    endtask

    task automatic press(input int b);
        c_btn[b] = 1'b1; idle(3);
        c_btn[b] = 1'b0; idle(3);
    endtask

    task automatic tap_pause();
        c_pause = 1'b1; idle(3);
        c_pause = 1'b0; idle(3);
    endtask

    task automatic set_col(input logic [1:0] v, input int hold);
        c_col = v;    idle(hold);
        c_col = NONE; idle(3);
    endtask

    int mv0;

    initial begin
        // Reset state, then release with all inputs low
        idle(3);
        c_rst = 1'b0;
        idle(3);

        // New game and base move rate
        press(0);
        mv0 = n_moves; frames(8);
        check("moves_first_8_frames", n_moves - mv0, 1);
        mv0 = n_moves; frames(80);
        check("moves_80_frames", n_moves - mv0, 10);

        // Four apples reach level 1, period becomes 7
        for (int i = 0; i < 4; i++) set_col(APPLE_COLLECTED, 5);
        mv0 = n_moves; frames(14);
        check("moves_period_7", n_moves - mv0, 2);

        // Pause freezes movement and ignores apples
        tap_pause();
        mv0 = n_moves;
        frames(50);
        set_col(APPLE_COLLECTED, 5);
        check("moves_in_pause", n_moves - mv0, 0);
        tap_pause();
        frames(10);

        // Lives: two life losses with resume, third ends the game
        set_col(COLLISION, 5);
        press(2);
        frames(3);
        set_col(COLLISION, 8);
        press(1);
        set_col(COLLISION, 4);
        frames(125);
        press(3);

        // Saturation of score (both widths) and level, then minimum period
        for (int i = 0; i < 260; i++) set_col(APPLE_COLLECTED, 2);
        frames(10);

        // Collision and pause arriving together: collision wins
        c_col = COLLISION; c_pause = 1'b1; idle(3);
        c_col = NONE;      c_pause = 1'b0; idle(3);
        press(0);
        frames(4);

        // Asynchronous reset between clock edges
        @(negedge clk);
        #2;
        reset = 1'b1; c_rst = 1'b1;
        #1;
        check("async_rst_state", bus.game_state, IDLE);
        check("async_rst_score", bus.score, 0);
        check("async_rst_level", bus.level, 0);
        check("async_rst_lives", bus.lives, 0);
        check("async_rst_move",  bus.move_tick, 0);
        check("async_rst_pulses",
              {bus.apple_trigger, bus.new_game, bus.life_lost}, 0);
        idle(2);
        c_rst = 1'b0;
        idle(3);
        frames(5);

        // Randomised play
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 9) == 0) c_btn[$urandom_range(0, 3)] ^= 1'b1;
            if ($urandom_range(0, 39) == 0) c_pause = ~c_pause;
            if ($urandom_range(0, 14) == 0) c_col = 2'($urandom_range(0, 2));
            tick($urandom_range(0, 2) == 0);
        end
        c_btn = '0; c_pause = 1'b0; c_col = NONE;
        idle(4);

        @(posedge clk);
        #3;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
